// File: rtl/frame_buffer.sv
// Pixel store between the depth comparator and scanout: zero-latency comparator
// read, registered scanout read, and a self-running clear sweep to CLEAR_PIXEL.
package common;
  typedef struct packed {
    logic [15:0] depth;
    logic [15:0] color;
  } pixel_t;
endpackage

module frame_buffer
  import common::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter pixel_t      CLEAR_PIXEL = '0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] address_x,
  input  logic [9:0] address_y,
  input  logic       write_enable,
  input  pixel_t     write_data,
  output pixel_t     read_data,
  input  logic       scan_enable,
  input  logic [9:0] scan_x,
  input  logic [9:0] scan_y,
  output pixel_t     scan_data,
  output logic       scan_valid,
  input  logic       clear_request,
  output logic       ready,
  output logic       clear_done
);
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] clear_index_reg, clear_index_next;
  logic             clear_done_reg, clear_done_next;
  logic             scan_valid_reg;
  pixel_t           scan_data_reg;

  pixel_t mem [DEPTH];

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  endfunction

  function automatic logic [IDX_W-1:0] linear(input logic [9:0] x, input logic [9:0] y);
    return IDX_W'(32'(y) * WIDTH + 32'(x));
  endfunction

  logic             comp_in_range, scan_in_range;
  logic [IDX_W-1:0] comp_index, scan_index;

  assign comp_in_range = in_range(address_x, address_y);
  assign scan_in_range = in_range(scan_x, scan_y);
  assign comp_index    = linear(address_x, address_y);
  assign scan_index    = linear(scan_x, scan_y);

  assign read_data  = (state_reg == READY && comp_in_range) ? mem[comp_index] : CLEAR_PIXEL;
  assign ready      = (state_reg == READY);
  assign clear_done = clear_done_reg;
  assign scan_valid = scan_valid_reg;
  assign scan_data  = scan_data_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= CLEAR;
      clear_index_reg <= '0;
      clear_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clear_index_reg <= clear_index_next;
      clear_done_reg  <= clear_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    clear_index_next = clear_index_reg;
    clear_done_next  = 1'b0;
    case (state_reg)
      CLEAR: begin
        if (clear_index_reg == LAST_INDEX) begin
          state_next       = READY;
          clear_index_next = '0;
          clear_done_next  = 1'b1;
        end else begin
          clear_index_next = clear_index_reg + 1'b1;
        end
      end
      READY: begin
        if (clear_request) begin
          state_next       = CLEAR;
          clear_index_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // The sweep owns the write port for its whole duration; comparator writes are dropped.
  always_ff @(posedge clock) begin
    if (state_reg == CLEAR) begin
      mem[clear_index_reg] <= CLEAR_PIXEL;
    end else if (write_enable && comp_in_range) begin
      mem[comp_index] <= write_data;
    end
  end

  // Scanout samples memory before any same-edge write lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_valid_reg <= 1'b0;
      scan_data_reg  <= CLEAR_PIXEL;
    end else begin
      scan_valid_reg <= scan_enable;
      if (scan_enable) begin
        scan_data_reg <= scan_in_range ? mem[scan_index] : CLEAR_PIXEL;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer at 4x3: vector table for read/write/scan,
// hand sequences for sweeps, clear requests and mid-sweep reset.
module tb_frame_buffer;
  import common::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] address_x = '0, address_y = '0;
  logic       write_enable = 1'b0;
  pixel_t     write_data = '0;
  pixel_t     read_data;
  logic       scan_enable = 1'b0;
  logic [9:0] scan_x = '0, scan_y = '0;
  pixel_t     scan_data;
  logic       scan_valid;
  logic       clear_request = 1'b0;
  logic       ready;
  logic       clear_done;

  int compared   = 0;
  int mismatched = 0;

  frame_buffer #(.WIDTH(4), .HEIGHT(3), .CLEAR_PIXEL('0)) dut (
    .clock(clock), .reset(reset),
    .address_x(address_x), .address_y(address_y),
    .write_enable(write_enable), .write_data(write_data), .read_data(read_data),
    .scan_enable(scan_enable), .scan_x(scan_x), .scan_y(scan_y),
    .scan_data(scan_data), .scan_valid(scan_valid),
    .clear_request(clear_request), .ready(ready), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] x, y;
    logic       we;
    int         wd;
    logic       se;
    logic [9:0] sx, sy;
    int         exp_rd;
    logic       exp_sv;
    int         exp_sd;
  } vec_t;

  function automatic logic [31:0] px(input int d);
    logic [31:0] p;
    p = {d[15:0], 16'(d * 257)};
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called on a sample edge right after the sweep has begun; counts ready-low cycles.
  task automatic sweep_check(input string name, input int repulse_at);
    int low;
    low = 0;
    while (ready !== 1'b1 && low < 100) begin
      clear_request = (low == repulse_at);
      write_enable  = 1'b1;
      address_x     = 10'd1;
      address_y     = 10'd1;
      write_data    = px(8);
      step();
      low++;
    end
    clear_request = 1'b0;
    write_enable  = 1'b0;
    check({name, "_len"}, low, 12);
    check({name, "_done_pulse"}, clear_done, 1'b1);
    step();
    check({name, "_done_drop"}, clear_done, 1'b0);
  endtask

  task automatic readback_all(input string name);
    scan_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      address_x = 10'(i % 4);
      address_y = 10'(i / 4);
      scan_x    = address_x;
      scan_y    = address_y;
      #1;
      check($sformatf("%s_read%0d", name, i), read_data, px(0));
      step();
      check($sformatf("%s_scan%0d", name, i), scan_data, px(0));
      check($sformatf("%s_valid%0d", name, i), scan_valid, 1'b1);
    end
    scan_enable = 1'b0;
    step();
    check({name, "_valid_off"}, scan_valid, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{10'd2, 10'd1, 1'b1, 5,  1'b0, 10'd0, 10'd0, 0,  1'b0, 0});
    vecs.push_back('{10'd2, 10'd1, 1'b0, 0,  1'b1, 10'd2, 10'd1, 5,  1'b1, 5});
    vecs.push_back('{10'd4, 10'd0, 1'b1, 9,  1'b0, 10'd0, 10'd0, 0,  1'b0, 5});
    vecs.push_back('{10'd4, 10'd0, 1'b0, 0,  1'b1, 10'd4, 10'd0, 0,  1'b1, 0});
    vecs.push_back('{10'd0, 10'd1, 1'b0, 0,  1'b1, 10'd0, 10'd1, 0,  1'b1, 0});
    vecs.push_back('{10'd1, 10'd2, 1'b1, 3,  1'b1, 10'd1, 10'd2, 0,  1'b1, 0});
    vecs.push_back('{10'd1, 10'd2, 1'b0, 0,  1'b1, 10'd1, 10'd2, 3,  1'b1, 3});
    vecs.push_back('{10'd1, 10'd2, 1'b1, 7,  1'b1, 10'd1, 10'd2, 3,  1'b1, 3});
    vecs.push_back('{10'd1, 10'd2, 1'b0, 0,  1'b1, 10'd1, 10'd2, 7,  1'b1, 7});
    vecs.push_back('{10'd3, 10'd2, 1'b1, 11, 1'b0, 10'd0, 10'd0, 0,  1'b0, 7});
    vecs.push_back('{10'd3, 10'd2, 1'b0, 0,  1'b1, 10'd3, 10'd2, 11, 1'b1, 11});
    vecs.push_back('{10'd3, 10'd2, 1'b0, 0,  1'b0, 10'd3, 10'd2, 11, 1'b0, 11});
    vecs.push_back('{10'd3, 10'd2, 1'b0, 0,  1'b1, 10'd3, 10'd3, 11, 1'b1, 0});
    vecs.push_back('{10'd0, 10'd3, 1'b1, 4,  1'b0, 10'd0, 10'd0, 0,  1'b0, 0});
    vecs.push_back('{10'd0, 10'd0, 1'b0, 0,  1'b0, 10'd0, 10'd0, 0,  1'b0, 0});

    // Reset state, then the power-up sweep.
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_scan_data", scan_data, px(0));
    check("rst_clear_done", clear_done, 1'b0);
    check("rst_read_data", read_data, px(0));
    @(negedge clock);
    reset = 1'b0;
    sweep_check("init_sweep", -1);
    check("init_ready", ready, 1'b1);
    readback_all("init");

    // Table-driven read/write/scan vectors.
    foreach (vecs[i]) begin
      address_x    = vecs[i].x;
      address_y    = vecs[i].y;
      write_enable = vecs[i].we;
      write_data   = px(vecs[i].wd);
      scan_enable  = vecs[i].se;
      scan_x       = vecs[i].sx;
      scan_y       = vecs[i].sy;
      #1;
      check($sformatf("vec%0d_read", i), read_data, px(vecs[i].exp_rd));
      step();
      check($sformatf("vec%0d_scan_valid", i), scan_valid, vecs[i].exp_sv);
      check($sformatf("vec%0d_scan_data", i), scan_data, px(vecs[i].exp_sd));
    end
    write_enable = 1'b0;
    scan_enable  = 1'b0;

    // Clear request with a same-cycle write, a repeated request mid-sweep, and dropped writes.
    address_x     = 10'd0;
    address_y     = 10'd0;
    write_enable  = 1'b1;
    write_data    = px(2);
    clear_request = 1'b1;
    #1;
    check("req_ready_before", ready, 1'b1);
    step();
    clear_request = 1'b0;
    write_enable  = 1'b0;
    check("req_ready_after", ready, 1'b0);
    sweep_check("req_sweep", 5);
    readback_all("after_clear");

    // Reset in the middle of a sweep.
    address_x    = 10'd2;
    address_y    = 10'd2;
    write_enable = 1'b1;
    write_data   = px(6);
    step();
    write_enable = 1'b0;
    scan_enable  = 1'b1;
    scan_x       = 10'd2;
    scan_y       = 10'd2;
    #1;
    check("pre_read_22", read_data, px(6));
    step();
    check("pre_scan_22", scan_data, px(6));
    clear_request = 1'b1;
    step();
    clear_request = 1'b0;
    #1;
    check("clear_read_masked", read_data, px(0));
    for (int i = 0; i < 6; i++) step();
    check("mid_sweep_scan_data", scan_data, px(6));
    check("mid_sweep_scan_valid", scan_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ready", ready, 1'b0);
    check("async_rst_scan_valid", scan_valid, 1'b0);
    check("async_rst_scan_data", scan_data, px(0));
    check("async_rst_clear_done", clear_done, 1'b0);
    @(negedge clock);
    reset       = 1'b0;
    scan_enable = 1'b0;
    sweep_check("rst_sweep", -1);
    readback_all("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
